// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, lane sizes
// and the request-legality helpers used at acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Unsigned sub-word widths only exist for loads.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return is_store;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
    case (f3)
      F3_H, F3_HU: return byte_off[0];
      F3_W:        return |byte_off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a word, and merges a
// store lane into a word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic [2:0]          funct3,
  input  logic [1:0]          byte_off,
  input  logic [WORDSIZE-1:0] rd_word,
  input  logic [WORDSIZE-1:0] st_data,
  output logic [WORDSIZE-1:0] ld_data,
  output logic [WORDSIZE-1:0] merged_word
);

  logic [BYTE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  always_comb begin
    sel_byte = rd_word[{byte_off, 3'b000} +: BYTE_W];
    sel_half = rd_word[{byte_off[1], 4'b0000} +: HALF_W];

    case (funct3)
      F3_B:    ld_data = {{(WORDSIZE-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
      F3_H:    ld_data = {{(WORDSIZE-HALF_W){sel_half[HALF_W-1]}}, sel_half};
      F3_BU:   ld_data = {{(WORDSIZE-BYTE_W){1'b0}}, sel_byte};
      F3_HU:   ld_data = {{(WORDSIZE-HALF_W){1'b0}}, sel_half};
      default: ld_data = rd_word;
    endcase

    merged_word = rd_word;
    case (funct3)
      F3_B:    merged_word[{byte_off, 3'b000} +: BYTE_W] = st_data[BYTE_W-1:0];
      F3_H:    merged_word[{byte_off[1], 4'b0000} +: HALF_W] = st_data[HALF_W-1:0];
      default: merged_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, word-granular memory access, sub-word
// loads extracted/extended here and sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int ADDRSIZE = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  input  logic [WORDSIZE-1:0] mem_rdata
);

  lsu_state_e          state_q, state_d;
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic [WORDSIZE-1:0] buf_q, buf_d;
  logic [WORDSIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                write_q, write_d;
  logic                resp_err_q, resp_err_d;

  logic [WORDSIZE-1:0] align_word;
  logic [WORDSIZE-1:0] ld_data;
  logic [WORDSIZE-1:0] merged_word;
  logic                out_of_range;
  logic                req_bad;

  assign out_of_range = |req_addr[WORDSIZE-1:ADDRSIZE+2];
  assign req_bad      = f3_illegal(req_write, req_funct3)
                      || f3_misaligned(req_funct3, req_addr[1:0])
                      || out_of_range;

  // Loads extract straight from the live read word; the merge works on the captured buffer.
  assign align_word = (state_q == ST_READ) ? mem_rdata : buf_q;

  lsu_lane_align #(
    .WORDSIZE(WORDSIZE)
  ) u_lane_align (
    .funct3      (funct3_q),
    .byte_off    (addr_q[1:0]),
    .rd_word     (align_word),
    .st_data     (wdata_q),
    .ld_data     (ld_data),
    .merged_word (merged_word)
  );

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    buf_d        = buf_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          if (req_bad) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end else if (!req_write) begin
            state_d = ST_READ;
          end else if (req_funct3 == F3_W) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_READ: begin
        mem_read     = 1'b1;
        buf_d        = mem_rdata;
        resp_rdata_d = ld_data;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read = 1'b1;
        buf_d    = mem_rdata;
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_write    = 1'b1;
        mem_wdata    = merged_word;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_WRITE: begin
        mem_write    = 1'b1;
        mem_wdata    = wdata_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      buf_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      buf_q        <= buf_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr   = {2'b00, addr_q[WORDSIZE-1:2]};
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic against a
// word-array memory model and an arithmetic reference of load/store semantics.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem    [32];
  logic [31:0] ref_mem [32];
  logic [31:0] last_rdata;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .WORDSIZE(32),
    .ADDRSIZE(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // dataMemory-compatible: combinational read, whole-word write on the clock edge.
  assign mem_rdata = dmem[mem_addr[4:0]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[4:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference semantics: size/alignment/range rules and little-endian lanes via shifts and masks.
  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat, output int nrd, output int nwr);
    int          size;
    int          idx;
    int          sh;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (wr) err = (f3 > 3'd2);
    else    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = err || ((a % size) != 0) || ((a / 4) >= 32);
    rd  = '0;
    lat = 1;
    nrd = 0;
    nwr = 0;
    if (!err) begin
      idx  = int'(a / 4);
      sh   = int'(a % 4) * 8;
      w    = ref_mem[idx];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
      if (!wr) begin
        v = (w >> sh) & mask;
        if (f3[2] == 1'b0 && size < 4 && v[size*8-1]) v = v | ~mask;
        rd  = v;
        lat = 2;
        nrd = 1;
      end else if (size == 4) begin
        ref_mem[idx] = wd;
        lat = 2;
        nwr = 1;
      end else begin
        ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        lat = 3;
        nrd = 1;
        nwr = 1;
      end
    end
  endtask

  task automatic do_op(input string tag, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat, e_nrd, e_nwr;
    int          cyc, nrd, nwr, nboth, nready, waitc;
    bit          got;
    model(wr, f3, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    check({tag, ".resp_one_cycle"}, 32'(resp_valid), 32'd0);
    check({tag, ".rdata_held"}, resp_rdata, last_rdata);
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    // Garbage while busy; must be ignored.
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cyc = 0; got = 0; nrd = 0; nwr = 0; nboth = 0; nready = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) nboth++;
      if (req_ready) nready++;
      if (resp_valid) got = 1;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(e_lat));
    check({tag, ".got_resp"}, 32'(got), 32'd1);
    check({tag, ".err"}, 32'(resp_err), 32'(e_err));
    check({tag, ".rdata"}, resp_rdata, e_rd);
    check({tag, ".mem_read_cycles"}, 32'(nrd), 32'(e_nrd));
    check({tag, ".mem_write_cycles"}, 32'(nwr), 32'(e_nwr));
    check({tag, ".strobe_overlap"}, 32'(nboth), 32'd0);
    check({tag, ".ready_low_busy"}, 32'(nready), 32'd0);
    last_rdata = resp_rdata;
  endtask

  initial begin
    int          nresp;
    logic [2:0]  f3;
    logic [31:0] saved;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int i = 0; i < 32; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[3]    = 32'h8899_AABB;
    ref_mem[3] = 32'h8899_AABB;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    last_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.strobes", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("reset.err", 32'(resp_err), 32'd0);
    check("reset.rdata", resp_rdata, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Sub-word and word loads from the preloaded word.
    do_op("lb_0f", 0, 3'b000, 32'h0F, 32'h0, 0);
    check("lb_0f.const", last_rdata, 32'hFFFF_FF88);
    do_op("lbu_0f", 0, 3'b100, 32'h0F, 32'h0, 0);
    check("lbu_0f.const", last_rdata, 32'h0000_0088);
    do_op("lh_0c", 0, 3'b001, 32'h0C, 32'h0, 0);
    check("lh_0c.const", last_rdata, 32'hFFFF_AABB);
    do_op("lw_0c", 0, 3'b010, 32'h0C, 32'h0, 0);
    check("lw_0c.const", last_rdata, 32'h8899_AABB);

    // Stores.
    do_op("sb_0d", 1, 3'b000, 32'h0D, 32'h1234_56CC, 0);
    check("sb_0d.word3", dmem[3], 32'h8899_CCBB);
    dmem[3]    = 32'h8899_AABB;
    ref_mem[3] = 32'h8899_AABB;
    do_op("sh_0e", 1, 3'b001, 32'h0E, 32'h0000_1234, 0);
    check("sh_0e.word3", dmem[3], 32'h1234_AABB);
    do_op("sw_10", 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
    check("sw_10.word4", dmem[4], 32'hDEAD_BEEF);

    // Errors: no memory access, one-cycle response.
    do_op("err_lw_0e", 0, 3'b010, 32'h0E, 32'h0, 0);
    do_op("err_lh_0d", 0, 3'b001, 32'h0D, 32'h0, 0);
    do_op("err_lw_80", 0, 3'b010, 32'h80, 32'h0, 0);
    do_op("err_f3_011", 0, 3'b011, 32'h00, 32'h0, 0);
    do_op("err_sbu", 1, 3'b100, 32'h04, 32'h55, 0);
    do_op("lw_7c_last", 0, 3'b010, 32'h7C, 32'h0, 0);

    // Back-to-back with req_valid held.
    do_op("b2b_sb", 1, 3'b000, 32'h21, 32'h0000_00A5, 1);
    do_op("b2b_lbu", 0, 3'b100, 32'h21, 32'h0, 1);
    req_valid = 1'b0;
    check("b2b_lbu.const", last_rdata, 32'h0000_00A5);

    // Reset while in RMW_RD: write abandoned, no response.
    saved = dmem[5];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h15; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.in_rmw_rd", {30'd0, mem_read, mem_write}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid.ready", 32'(req_ready), 32'd1);
    check("rst_mid.strobes", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("rst_mid.err_rdata", {resp_rdata[30:0], resp_err}, 32'd0);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    check("rst_mid.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    nresp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_write) nresp++;
    end
    check("rst_mid.no_resp", 32'(nresp), 32'd0);
    check("rst_mid.word5", dmem[5], saved);
    last_rdata = '0;

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9, 0) < 8) f3 = legal_f3[$urandom_range(4, 0)];
      else                          f3 = 3'($urandom);
      do_op($sformatf("rand%0d", i), bit'($urandom_range(1, 0)), f3,
            32'($urandom_range(32'h8F, 0)), $urandom, bit'($urandom_range(1, 0)));
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 32; i++) check($sformatf("final.word%0d", i), dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
